// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store controller between the CPU execute stage and a 32x8
//            data memory. Accepts one request at a time (valid/ready), drives
//            the memory address/write-data/write-strobe, and returns a single
//            cycle response. Adds atomic read-modify-write bit set / bit clear.
// Ports    : Clk, Reset              - clock (rising edge), sync active-high reset
//            Req_valid/Req_ready     - request handshake
//            Req_op                  - 00 LOAD, 01 STORE, 10 SETB, 11 CLRB
//            Req_addr/Req_wdata/Req_bit - byte address, store data, bit index
//            Rsp_valid/Rsp_data/Rsp_err - one-cycle response pulse
//            Mem_Addr/Mem_Wdata/Mem_En  - memory address, write data, write strobe
//            Mem_Rdata               - combinational memory read data
// Options  : `define LSU_PROTECT_EN to reject writes at or above PROT_BASE
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 32,
  parameter int PROT_BASE = 'h18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [1:0]        Req_op,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [7:0]        Req_wdata,
  input  logic [2:0]        Req_bit,
  output logic              Rsp_valid,
  output logic [7:0]        Rsp_data,
  output logic              Rsp_err,
  output logic [4:0]        Mem_Addr,
  output logic [7:0]        Mem_Wdata,
  output logic              Mem_En,
  input  logic [7:0]        Mem_Rdata
);

  localparam int                c_MEM_AW    = 5;
  localparam logic [ADDR_W-1:0] c_DEPTH     = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] c_PROT_BASE = ADDR_W'(PROT_BASE);

  localparam logic [1:0] c_OP_LOAD  = 2'b00;
  localparam logic [1:0] c_OP_STORE = 2'b01;
  localparam logic [1:0] c_OP_SETB  = 2'b10;

`ifdef LSU_PROTECT_EN
  localparam logic c_PROT_EN = 1'b1;
`else
  localparam logic c_PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]          r_op;
  logic [2:0]          r_bit;
  logic [c_MEM_AW-1:0] r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic [7:0]          r_rsp_data;
  logic                r_rsp_err;

  logic       w_out_of_range;
  logic       w_protected;
  logic       w_reject;
  logic [7:0] w_bit_mask;
  logic [7:0] w_modified;

  // Full-width compare: any upper address bit set lands out of range.
  assign w_out_of_range = (Req_addr >= c_DEPTH);
  // Only writes are protected; loads from the protected window are allowed.
  assign w_protected    = c_PROT_EN && (Req_op != c_OP_LOAD) && (Req_addr >= c_PROT_BASE);
  assign w_reject       = w_out_of_range || w_protected;

  assign w_bit_mask = 8'b1 << r_bit;
  assign w_modified = (r_op == c_OP_SETB) ? (Mem_Rdata | w_bit_mask)
                                          : (Mem_Rdata & ~w_bit_mask);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    Req_ready   = 1'b0;
    Rsp_valid   = 1'b0;
    Mem_En      = 1'b0;
    case (r_state)
      S_IDLE: begin
        Req_ready = 1'b1;
        if (Req_valid) begin
          if (w_reject) begin
            w_state_nxt = S_RESP;
          end else if (Req_op == c_OP_STORE) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        w_state_nxt = (r_op == c_OP_LOAD) ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        Mem_En      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        Rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: request latches, memory drive registers and response registers.
  // Memory address/data only move when entering READ/WRITE so they hold their
  // last values otherwise (rejected requests never touch them).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_op        <= 2'b00;
      r_bit       <= 3'b000;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req_valid) begin
            r_op  <= Req_op;
            r_bit <= Req_bit;
            if (w_reject) begin
              r_rsp_data <= 8'h00;
              r_rsp_err  <= 1'b1;
            end else begin
              r_mem_addr <= Req_addr[c_MEM_AW-1:0];
              if (Req_op == c_OP_STORE) begin
                r_mem_wdata <= Req_wdata;
              end
            end
          end
        end
        S_READ: begin
          if (r_op == c_OP_LOAD) begin
            r_rsp_data <= Mem_Rdata;
            r_rsp_err  <= 1'b0;
          end else begin
            r_mem_wdata <= w_modified;
          end
        end
        S_WRITE: begin
          // Store data or the modified byte is already in the write register.
          r_rsp_data <= r_mem_wdata;
          r_rsp_err  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign Mem_Addr  = r_mem_addr;
  assign Mem_Wdata = r_mem_wdata;
  assign Rsp_data  = r_rsp_data;
  assign Rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl with a behavioural 32x8
//            memory, a reference memory model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Req_valid = 1'b0;
  logic       Req_ready;
  logic [1:0] Req_op = 2'b00;
  logic [7:0] Req_addr = 8'h00;
  logic [7:0] Req_wdata = 8'h00;
  logic [2:0] Req_bit = 3'b000;
  logic       Rsp_valid;
  logic [7:0] Rsp_data;
  logic       Rsp_err;
  logic [4:0] Mem_Addr;
  logic [7:0] Mem_Wdata;
  logic       Mem_En;
  logic [7:0] Mem_Rdata;

  lsu_mem_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req_valid (Req_valid),
    .Req_ready (Req_ready),
    .Req_op    (Req_op),
    .Req_addr  (Req_addr),
    .Req_wdata (Req_wdata),
    .Req_bit   (Req_bit),
    .Rsp_valid (Rsp_valid),
    .Rsp_data  (Rsp_data),
    .Rsp_err   (Rsp_err),
    .Mem_Addr  (Mem_Addr),
    .Mem_Wdata (Mem_Wdata),
    .Mem_En    (Mem_En),
    .Mem_Rdata (Mem_Rdata)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_count = 0;
  int exp_writes = 0;
  int last_acc = 0;
  int last_lat = 0;
  logic [4:0] en_addr = 5'd0;
  logic [7:0] en_data = 8'h00;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic       pl_en = 1'b0;
  logic [4:0] pl_a = 5'd0;
  logic [7:0] pl_d = 8'h00;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural memory: combinational read, write on rising edge.
  always @(posedge Clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (Mem_En) mem[Mem_Addr] <= Mem_Wdata;
  end
  assign Mem_Rdata = mem[Mem_Addr];

  // Response monitor / scoreboard pop
  always @(negedge Clk) begin
    if (Mem_En) begin
      en_count = en_count + 1;
      en_addr  = Mem_Addr;
      en_data  = Mem_Wdata;
    end
    if (Rsp_valid) begin
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_rsp: got data=%h err=%b, required no response", Rsp_data, Rsp_err);
      end else begin
        mon_e = q.pop_front();
        if (Rsp_data !== mon_e.data) begin
          errors = errors + 1;
          $display("FAIL rsp_data: got %h required %h", Rsp_data, mon_e.data);
        end
        checks = checks + 1;
        if (Rsp_err !== mon_e.err) begin
          errors = errors + 1;
          $display("FAIL rsp_err: got %b required %b", Rsp_err, mon_e.err);
        end
        checks = checks + 1;
        if ((cyc - mon_e.acc) != mon_e.lat) begin
          errors = errors + 1;
          $display("FAIL rsp_latency: got %0d required %0d", cyc - mon_e.acc, mon_e.lat);
        end
        checks = checks + 1;
        if (Req_ready !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL ready_during_rsp: got %b required 0", Req_ready);
        end
      end
    end
  end

  // Reference model: expected response and reference memory update.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] addr,
                                 input logic [7:0] wd, input logic [2:0] b);
    exp_t e;
    logic prot;
    logic [7:0] v;
    prot = 1'b0;
`ifdef LSU_PROTECT_EN
    prot = (op != 2'b00) && (addr >= 8'h18);
`endif
    e.acc = 0;
    if (addr >= 8'd32 || prot) begin
      e.data = 8'h00; e.err = 1'b1; e.lat = 1;
    end else begin
      e.err = 1'b0;
      v = ref_mem[addr[4:0]];
      case (op)
        2'b00: begin e.data = v; e.lat = 2; end
        2'b01: begin e.data = wd; e.lat = 2; ref_mem[addr[4:0]] = wd; exp_writes++; end
        2'b10: begin e.data = v | (8'd1 << b); e.lat = 3; ref_mem[addr[4:0]] = e.data; exp_writes++; end
        default: begin e.data = v & ~(8'd1 << b); e.lat = 3; ref_mem[addr[4:0]] = e.data; exp_writes++; end
      endcase
    end
    return e;
  endfunction

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge Clk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Present a request, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [1:0] op, input logic [7:0] addr,
                      input logic [7:0] wd, input logic [2:0] b);
    exp_t e;
    int n;
    Req_valid = 1'b1; Req_op = op; Req_addr = addr; Req_wdata = wd; Req_bit = b;
    n = 0;
    while (!Req_ready && n < 30) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!Req_ready) begin
      errors++;
      $display("FAIL accept_timeout: got ready=%b required 1", Req_ready);
    end else begin
      e = model(op, addr, wd, b);
      e.acc = cyc;
      q.push_back(e);
      last_acc = cyc;
      last_lat = e.lat;
    end
    @(negedge Clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d pending required 0", q.size());
      q.delete();
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req_valid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (Req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", Req_ready); end
    checks++; if (Rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", Rsp_valid); end
    checks++; if (Rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h required 00", Rsp_data); end
    checks++; if (Rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", Rsp_err); end
    checks++; if (Mem_En !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b required 0", Mem_En); end
    checks++; if (Mem_Addr !== 5'd0) begin errors++; $display("FAIL reset_mem_addr: got %h required 00", Mem_Addr); end
    checks++; if (Mem_Wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h required 00", Mem_Wdata); end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_store_load();
    int en0;
    en0 = en_count;
    send(2'b01, 8'h05, 8'hA5, 3'd0);
    Req_valid = 1'b0;
    drain();
    checks++; if (en_count - en0 != 1) begin errors++; $display("FAIL store_en_pulses: got %0d required 1", en_count - en0); end
    checks++; if (en_addr !== 5'd5) begin errors++; $display("FAIL store_en_addr: got %h required 05", en_addr); end
    checks++; if (en_data !== 8'hA5) begin errors++; $display("FAIL store_en_data: got %h required a5", en_data); end
    en0 = en_count;
    send(2'b00, 8'h05, 8'h00, 3'd0);
    Req_valid = 1'b0;
    drain();
    checks++; if (en_count != en0) begin errors++; $display("FAIL load_en_pulses: got %0d required 0", en_count - en0); end
  endtask

  task automatic test_bit_ops();
    int en0;
    int w0;
    logic [2:0] bits [3];
    logic [1:0] ops [3];
    bits[0] = 3'd0; ops[0] = 2'b10;
    bits[1] = 3'd7; ops[1] = 2'b11;
    bits[2] = 3'd4; ops[2] = 2'b10;   // bit already set: write still happens
    preload(5'h1B, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      en0 = en_count; w0 = exp_writes;
      send(ops[i], 8'h1B, 8'h00, bits[i]);
      Req_valid = 1'b0;
      drain();
      checks++;
      if (en_count - en0 != exp_writes - w0) begin
        errors++;
        $display("FAIL bitop_en_pulses[%0d]: got %0d required %0d", i, en_count - en0, exp_writes - w0);
      end
    end
  endtask

  task automatic test_errors();
    int en0;
    int bad;
    en0 = en_count;
    send(2'b00, 8'h20, 8'h00, 3'd0);
    Req_valid = 1'b0; drain();
    send(2'b01, 8'hFF, 8'h5A, 3'd0);
    Req_valid = 1'b0; drain();
    send(2'b10, 8'h80, 8'h00, 3'd1);
    Req_valid = 1'b0; drain();
    checks++; if (en_count != en0) begin errors++; $display("FAIL err_en_pulses: got %0d required 0", en_count - en0); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL err_mem_unchanged: got %0d bad bytes required 0", bad); end
  endtask

  task automatic test_back_to_back();
    int acc_prev;
    int lat_prev;
    logic [1:0] ops [4];
    logic [7:0] adr [4];
    ops[0] = 2'b01; adr[0] = 8'h0A;
    ops[1] = 2'b00; adr[1] = 8'h0A;
    ops[2] = 2'b10; adr[2] = 8'h0A;
    ops[3] = 2'b00; adr[3] = 8'h40;
    acc_prev = 0; lat_prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], adr[i], 8'h3C, 3'd3);
      if (i > 0) begin
        checks++;
        if (last_acc - acc_prev != lat_prev + 1) begin
          errors++;
          $display("FAIL b2b_accept_gap[%0d]: got %0d required %0d", i, last_acc - acc_prev, lat_prev + 1);
        end
      end
      acc_prev = last_acc; lat_prev = last_lat;
      // Scramble inputs mid-operation; they must be ignored.
      Req_op = 2'($urandom_range(0, 3)); Req_addr = 8'($urandom_range(0, 255));
      Req_wdata = 8'($urandom_range(0, 255)); Req_bit = 3'($urandom_range(0, 7));
    end
    Req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int en0;
    int n;
    en0 = en_count;
    Req_valid = 1'b1; Req_op = 2'b10; Req_addr = 8'h03; Req_bit = 3'd2;
    n = 0;
    while (!Req_ready && n < 30) begin @(negedge Clk); n++; end
    @(negedge Clk);          // now in READ
    Reset = 1'b1; Req_valid = 1'b0;
    @(negedge Clk);
    checks++; if (Req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle: got %b required 1", Req_ready); end
    checks++; if (Rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp: got %b required 0", Rsp_valid); end
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    checks++; if (en_count != en0) begin errors++; $display("FAIL mid_reset_en: got %0d required 0", en_count - en0); end
    checks++; if (mem[3] !== ref_mem[3]) begin errors++; $display("FAIL mid_reset_mem: got %h required %h", mem[3], ref_mem[3]); end
  endtask

  task automatic test_protect();
    int en0;
    int w0;
    en0 = en_count; w0 = exp_writes;
    send(2'b01, 8'h18, 8'h55, 3'd0);
    Req_valid = 1'b0; drain();
    send(2'b00, 8'h18, 8'h00, 3'd0);
    Req_valid = 1'b0; drain();
    checks++;
    if (en_count - en0 != exp_writes - w0) begin
      errors++;
      $display("FAIL protect_en_pulses: got %0d required %0d", en_count - en0, exp_writes - w0);
    end
  endtask

  task automatic test_final_mem();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL final_mem: got %0d bad bytes required 0", bad); end
  endtask

  initial begin
    @(negedge Clk);
    for (int i = 0; i < 32; i++) preload(5'(i), 8'((i * 37 + 11) & 8'hFF));
    test_reset();
    test_store_load();
    test_bit_ops();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_protect();
    test_final_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller between the CPU execute stage and the 32x8 data memory. It accepts one memory request at a time over a valid/ready handshake and drives the memory's address, write-data and write-enable. It returns read data or a status over a single-cycle response pulse. It also performs atomic read-modify-write bit-set and bit-clear operations, which the memory cannot do on its own.

Parameters:
ADDR_W, 8, width of the request address from the CPU
DEPTH, 32, number of implemented memory bytes; addresses >= DEPTH are out of range
PROT_BASE, 8'h18, first write-protected address (used only with LSU_PROTECT_EN)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset
Req_valid  input  1  request present
Req_ready  output  1  controller can accept a request
Req_op  input  2  00 LOAD, 01 STORE, 10 SETB, 11 CLRB
Req_addr  input  ADDR_W  byte address
Req_wdata  input  8  store data
Req_bit  input  3  bit index for SETB/CLRB
Rsp_valid  output  1  one-cycle response pulse
Rsp_data  output  8  load data or post-modify value
Rsp_err  output  1  request rejected
Mem_Addr  output  5  to memory Address
Mem_Wdata  output  8  to memory Data_in
Mem_En  output  1  to memory En (write strobe)
Mem_Rdata  input  8  from memory Data_out (combinational read)

Behaviour:
- One clock (Clk); synchronous, active-high reset (Reset). Reset forces state IDLE, Req_ready=1, Rsp_valid=0, Rsp_data=0, Rsp_err=0, Mem_Addr=0, Mem_Wdata=0, Mem_En=0.
- States: IDLE, READ, WRITE, RESP. Req_ready=1 only in IDLE. A request is accepted on a rising edge where Req_valid && Req_ready. On acceptance the controller latches op, addr[4:0], wdata and bit.
- Transitions from IDLE on accept:
  - Out-of-range address (Req_addr >= DEPTH): go to RESP with err=1, data=0. No memory access.
  - LOAD, SETB, CLRB: go to READ.
  - STORE: go to WRITE with Mem_Wdata=Req_wdata.
- READ (1 cycle): Mem_Addr = latched address. At the end of the cycle, capture Mem_Rdata.
  - LOAD: go to RESP with data = captured byte.
  - SETB: go to WRITE with Mem_Wdata = captured | (1<<bit).
  - CLRB: go to WRITE with Mem_Wdata = captured & ~(1<<bit).
- WRITE (1 cycle): Mem_En=1, Mem_Addr and Mem_Wdata stable. Go to RESP.
  - STORE: data = Mem_Wdata.
  - SETB/CLRB: data = modified value.
- RESP (1 cycle): Rsp_valid=1, Rsp_data and Rsp_err valid. Next state IDLE. No response backpressure.
- Mem_En is decoded from state and is high only in WRITE. It is never high in any other state, including error paths.
- Mem_Addr and Mem_Wdata hold their last values outside READ/WRITE.
- Latency from accept edge to Rsp_valid high:
  - LOAD: 2 cycles
  - STORE: 2 cycles
  - SETB/CLRB: 3 cycles
  - error: 1 cycle
- Back-to-back throughput: the next request can be accepted in the first IDLE cycle after RESP.
- Req_* inputs are ignored while not in IDLE. Changing them mid-operation has no effect.
- SETB/CLRB on a bit already in the target state still performs the write. The response data equals the unchanged byte.
- Reset in any state returns to IDLE on the next edge. No response is emitted for the aborted operation. Reset asserted during WRITE: the memory's own reset dominates that edge.
- Req_bit is fully decoded (0..7). Address compare uses the full ADDR_W bits, so upper bits set counts as out of range.

Optional Feature:
LSU_PROTECT_EN
- Defined: STORE/SETB/CLRB to an in-range address >= PROT_BASE is rejected. The controller goes IDLE->RESP with Rsp_err=1 and Rsp_data=0, and Mem_En never asserts. LOAD from the protected range is allowed.
- Undefined: PROT_BASE is unused and all in-range addresses are writable.

Test Plan:
- Reset then idle: hold Reset 2 cycles -> Req_ready=1; Rsp_valid, Rsp_data, Rsp_err, Mem_En, Mem_Addr all 0.
- STORE addr 0x05 data 0xA5, then LOAD 0x05 -> Mem_En high exactly one cycle with Mem_Addr=5 and Mem_Wdata=0xA5; store response 2 cycles after accept. Load Rsp_data=0xA5, Rsp_err=0, 2 cycles after accept.
- Memory preloaded 0xF0 at 0x1B; SETB bit 0, then CLRB bit 7 -> responses 0xF1 then 0x71, each 3 cycles after accept; each op has one Mem_En pulse.
- LOAD addr 0x20 and STORE addr 0xFF -> Rsp_err=1, Rsp_data=0, 1 cycle after accept; no Mem_En pulse; memory unchanged.
- Req_valid held high with 4 queued requests -> Req_ready low from accept through RESP; each accept on the first IDLE cycle; responses in order.
- Reset asserted in READ of a SETB to 0x03 -> IDLE next cycle, no Rsp_valid, no Mem_En. With LSU_PROTECT_EN: STORE 0x18 -> Rsp_err=1 and no write; LOAD 0x18 succeeds.
